// File: rtl/mempool_pkg.sv
// rtl/mempool_pkg.sv - shared opcodes, reservation type and SC result codes for the TCDM adapter
package mempool_pkg;

    typedef logic [3:0] amo_t;

    localparam amo_t AmoNone = 4'h0;
    localparam amo_t AmoSwap = 4'h1;
    localparam amo_t AmoAdd  = 4'h2;
    localparam amo_t AmoAnd  = 4'h3;
    localparam amo_t AmoOr   = 4'h4;
    localparam amo_t AmoXor  = 4'h5;
    localparam amo_t AmoMax  = 4'h6;
    localparam amo_t AmoMaxu = 4'h7;
    localparam amo_t AmoMin  = 4'h8;
    localparam amo_t AmoMinu = 4'h9;
    localparam amo_t AmoLR   = 4'hA;
    localparam amo_t AmoSC   = 4'hB;

    localparam int unsigned ResIdWidth   = 5;
    localparam int unsigned ResAddrWidth = 8;

    typedef struct packed {
        logic                    valid;
        logic [ResIdWidth-1:0]   id;
        logic [ResAddrWidth-1:0] addr;
    } reservation_t;

    localparam logic ScSuccess = 1'b0;
    localparam logic ScFail    = 1'b1;

    function automatic logic is_rmw_amo(input amo_t op);
        return (op >= AmoSwap) && (op <= AmoMinu);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small circular FIFO with occupancy count and optional fall-through
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         push_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         pop_i
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  bypass, do_write, do_read;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A bypassed word that is popped in the same cycle never lands in storage.
    assign bypass   = FALL_THROUGH && (cnt_q == '0) && push_i;
    assign empty_o  = (cnt_q == '0) && !bypass;
    assign usage_o  = cnt_q;
    assign data_o   = bypass ? data_i : mem_q[rd_ptr_q];
    assign do_read  = pop_i && (cnt_q != '0);
    assign do_write = push_i && !(bypass && pop_i) && ((cnt_q != CntWidth'(DEPTH)) || do_read);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_read)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntWidth'(do_write) - CntWidth'(do_read);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_amo_alu.sv
// rtl/tcdm_amo_alu.sv - combinational AMO datapath: new = op(old, operand)
module tcdm_amo_alu
    import mempool_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  amo_t                 amo_i,
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] operand_i,
    output logic [DataWidth-1:0] new_o
);

    always_comb begin
        new_o = old_i;
        case (amo_i)
            AmoSwap: new_o = operand_i;
            AmoAdd:  new_o = old_i + operand_i;
            AmoAnd:  new_o = old_i & operand_i;
            AmoOr:   new_o = old_i | operand_i;
            AmoXor:  new_o = old_i ^ operand_i;
            AmoMax:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
            AmoMaxu: new_o = (old_i > operand_i) ? old_i : operand_i;
            AmoMin:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
            AmoMinu: new_o = (old_i < operand_i) ? old_i : operand_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/tcdm_atomic_adapter.sv
// rtl/tcdm_atomic_adapter.sv - per-bank TCDM adapter: plain access, AMO read-modify-write, LR/SC
module tcdm_atomic_adapter
    import mempool_pkg::*;
#(
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned BeWidth         = DataWidth / 8,
    parameter int unsigned AddrWidth       = ResAddrWidth,
    parameter int unsigned MetaWidth       = 16,
    parameter int unsigned IdWidth         = ResIdWidth,
    parameter int unsigned NumReservations = 4,
    parameter int unsigned RespDepth       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic                 in_write_i,
    input  logic [3:0]           in_amo_i,
    input  logic [DataWidth-1:0] in_wdata_i,
    input  logic [BeWidth-1:0]   in_be_i,
    input  logic [IdWidth-1:0]   in_id_i,
    input  logic [MetaWidth-1:0] in_meta_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_rdata_o,
    output logic [MetaWidth-1:0] out_meta_o,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_addr_o,
    output logic [DataWidth-1:0] bank_wdata_o,
    output logic [BeWidth-1:0]   bank_be_o,
    input  logic [DataWidth-1:0] bank_rdata_i
);

    typedef enum logic {StIdle, StAmoWb} state_e;

    localparam int unsigned IdxWidth  = (NumReservations > 1) ? $clog2(NumReservations) : 1;
    localparam int unsigned CntWidth  = $clog2(RespDepth + 1);
    localparam int unsigned FifoWidth = DataWidth + MetaWidth;

    state_e                 state_q, state_d;
    reservation_t           res_q [NumReservations];
    reservation_t           res_d [NumReservations];
    logic [IdxWidth-1:0]    victim_q, victim_d;
    logic                   pend_q, pend_sc_q, sc_res_q;
    logic [MetaWidth-1:0]   meta_q;
    logic [AddrWidth-1:0]   addr_q;
    amo_t                   op_q;
    logic [DataWidth-1:0]   operand_q;

    logic                   is_lr, is_sc, is_amo, is_wr, is_rd, accept, sc_ok, inflight;
    logic [CntWidth-1:0]    fifo_cnt;
    logic [CntWidth:0]      used;
    logic                   lr_hit, lr_free;
    logic [IdxWidth-1:0]    hit_idx, free_idx;
    logic [DataWidth-1:0]   amo_new, push_rdata;
    logic                   fifo_push, fifo_empty;
    logic [FifoWidth-1:0]   fifo_rdata;

    assign is_lr  = (in_amo_i == AmoLR);
    assign is_sc  = (in_amo_i == AmoSC);
    assign is_amo = is_rmw_amo(in_amo_i);
    assign is_wr  = !(is_lr || is_sc || is_amo) && in_write_i;
    assign is_rd  = !(is_lr || is_sc || is_amo) && !in_write_i;

    // A response slot is reserved for anything accepted last cycle or being written back now.
    assign inflight   = pend_q || (state_q == StAmoWb);
    assign used       = {1'b0, fifo_cnt} + {{CntWidth{1'b0}}, inflight};
    assign in_ready_o = (state_q == StIdle) && (is_wr || (used < (CntWidth + 1)'(RespDepth)));
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        sc_ok = 1'b0;
        for (int i = 0; i < NumReservations; i++) begin
            if (res_q[i].valid && res_q[i].id == in_id_i && res_q[i].addr == in_addr_i) sc_ok = 1'b1;
        end
    end

    always_comb begin
        res_d    = res_q;
        victim_d = victim_q;
        lr_hit   = 1'b0;
        lr_free  = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < NumReservations; i++) begin
            if (!lr_hit && res_q[i].valid && res_q[i].id == in_id_i) begin
                lr_hit  = 1'b1;
                hit_idx = IdxWidth'(i);
            end
            if (!lr_free && !res_q[i].valid) begin
                lr_free  = 1'b1;
                free_idx = IdxWidth'(i);
            end
        end
        if (state_q == StAmoWb) begin
            for (int i = 0; i < NumReservations; i++) begin
                if (res_q[i].addr == addr_q) res_d[i].valid = 1'b0;
            end
        end else if (accept) begin
            for (int i = 0; i < NumReservations; i++) begin
                if ((is_wr || (is_sc && sc_ok)) && res_q[i].addr == in_addr_i) res_d[i].valid = 1'b0;
                if (is_sc && res_q[i].id == in_id_i) res_d[i].valid = 1'b0;
            end
            if (is_lr) begin
                if (lr_hit) begin
                    res_d[hit_idx] = '{valid: 1'b1, id: in_id_i, addr: in_addr_i};
                end else if (lr_free) begin
                    res_d[free_idx] = '{valid: 1'b1, id: in_id_i, addr: in_addr_i};
                end else begin
                    res_d[victim_q] = '{valid: 1'b1, id: in_id_i, addr: in_addr_i};
                    victim_d = (victim_q == IdxWidth'(NumReservations - 1)) ? '0 : victim_q + 1'b1;
                end
            end
        end
    end

    tcdm_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .amo_i     (op_q),
        .old_i     (bank_rdata_i),
        .operand_i (operand_q),
        .new_o     (amo_new)
    );

    always_comb begin
        state_d      = state_q;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_amo) state_d = StAmoWb;
                    bank_req_o  = is_sc ? sc_ok : 1'b1;
                    bank_we_o   = is_wr || (is_sc && sc_ok);
                    bank_addr_o = in_addr_i;
                    if (is_wr || is_sc) begin
                        bank_wdata_o = in_wdata_i;
                        bank_be_o    = in_be_i;
                    end
                end
            end
            StAmoWb: begin
                state_d      = StIdle;
                bank_req_o   = 1'b1;
                bank_we_o    = 1'b1;
                bank_addr_o  = addr_q;
                bank_wdata_o = amo_new;
                bank_be_o    = '1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            victim_q  <= '0;
            pend_q    <= 1'b0;
            pend_sc_q <= 1'b0;
            sc_res_q  <= ScSuccess;
            meta_q    <= '0;
            addr_q    <= '0;
            op_q      <= AmoNone;
            operand_q <= '0;
            for (int i = 0; i < NumReservations; i++) res_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            victim_q  <= victim_d;
            res_q     <= res_d;
            pend_q    <= accept && (is_rd || is_lr || is_sc);
            pend_sc_q <= accept && is_sc;
            sc_res_q  <= sc_ok ? ScSuccess : ScFail;
            if (accept) begin
                meta_q    <= in_meta_i;
                addr_q    <= in_addr_i;
                op_q      <= in_amo_i;
                operand_q <= in_wdata_i;
            end
        end
    end

    // AMO_WB pushes the pre-modification word, which is still on bank_rdata_i.
    assign fifo_push  = pend_q || (state_q == StAmoWb);
    assign push_rdata = (pend_q && pend_sc_q) ? {{(DataWidth - 1){1'b0}}, sc_res_q} : bank_rdata_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (FifoWidth),
        .DEPTH        (RespDepth)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .empty_o (fifo_empty),
        .usage_o (fifo_cnt),
        .data_i  ({push_rdata, meta_q}),
        .push_i  (fifo_push),
        .data_o  (fifo_rdata),
        .pop_i   (out_ready_i)
    );

    assign out_valid_o = !fifo_empty;
    assign out_rdata_o = fifo_empty ? '0 : fifo_rdata[FifoWidth-1:MetaWidth];
    assign out_meta_o  = fifo_empty ? '0 : fifo_rdata[MetaWidth-1:0];

endmodule

// File: tb/tb_tcdm_atomic_adapter.sv
// tb/tb_tcdm_atomic_adapter.sv - scoreboard bench for tcdm_atomic_adapter with SRAM and reference model
module tb_tcdm_atomic_adapter;
    import mempool_pkg::*;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 8;
    localparam int MW = 16;
    localparam int IW = 5;
    localparam int NR = 4;
    localparam int RD = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          in_valid_i, in_ready_o, in_write_i;
    logic [AW-1:0] in_addr_i;
    logic [3:0]    in_amo_i;
    logic [DW-1:0] in_wdata_i;
    logic [BW-1:0] in_be_i;
    logic [IW-1:0] in_id_i;
    logic [MW-1:0] in_meta_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] out_rdata_o;
    logic [MW-1:0] out_meta_o;
    logic          bank_req_o, bank_we_o;
    logic [AW-1:0] bank_addr_o;
    logic [DW-1:0] bank_wdata_o;
    logic [BW-1:0] bank_be_o;
    logic [DW-1:0] bank_rdata_i;

    tcdm_atomic_adapter #(
        .DataWidth(DW), .BeWidth(BW), .AddrWidth(AW), .MetaWidth(MW),
        .IdWidth(IW), .NumReservations(NR), .RespDepth(RD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
        .in_write_i(in_write_i), .in_amo_i(in_amo_i), .in_wdata_i(in_wdata_i),
        .in_be_i(in_be_i), .in_id_i(in_id_i), .in_meta_i(in_meta_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rdata_o(out_rdata_o), .out_meta_o(out_meta_o),
        .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
        .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // SRAM bank with one-cycle read latency
    logic [DW-1:0] sram [256];
    logic          sram_clr;
    always @(posedge clk_i) begin
        if (sram_clr) begin
            for (int i = 0; i < 256; i++) sram[i] <= '0;
            bank_rdata_i <= '0;
        end else if (bank_req_o) begin
            if (bank_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (bank_be_o[b]) sram[bank_addr_o][8*b +: 8] <= bank_wdata_o[8*b +: 8];
            end else begin
                bank_rdata_i <= sram[bank_addr_o];
            end
        end
    end

    logic rand_mode, ready_level;
    always begin
        @(posedge clk_i);
        #1;
        out_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Reference model: memory image, reservation table, expected response queue
    typedef struct packed {
        logic [DW-1:0] rdata;
        logic [MW-1:0] meta;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] ref_mem [256];
    bit            rv [NR];
    logic [IW-1:0] rid [NR];
    logic [AW-1:0] radr [NR];
    int            rvic;
    logic [MW-1:0] meta_cnt;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] amo_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'h1: return b;
            4'h2: return a + b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return ($signed(a) > $signed(b)) ? a : b;
            4'h7: return (a > b) ? a : b;
            4'h8: return ($signed(a) < $signed(b)) ? a : b;
            4'h9: return (a < b) ? a : b;
            default: return a;
        endcase
    endfunction

    task automatic kill_addr(input logic [AW-1:0] a);
        for (int i = 0; i < NR; i++) if (radr[i] == a) rv[i] = 0;
    endtask

    task automatic model_accept(input logic [3:0] op, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [BW-1:0] be, input logic [IW-1:0] id,
                                input logic [MW-1:0] meta);
        logic [DW-1:0] old = ref_mem[a];
        int slot = -1;
        bit ok = 0;
        if (op >= 4'h1 && op <= 4'h9) begin
            ref_mem[a] = amo_ref(op, old, d);
            kill_addr(a);
            exp_q.push_back({old, meta});
        end else if (op == 4'hA) begin
            exp_q.push_back({old, meta});
            for (int i = 0; i < NR; i++) if (slot < 0 && rv[i] && rid[i] == id) slot = i;
            for (int i = 0; i < NR; i++) if (slot < 0 && !rv[i]) slot = i;
            if (slot < 0) begin
                slot = rvic;
                rvic = (rvic + 1) % NR;
            end
            rv[slot] = 1; rid[slot] = id; radr[slot] = a;
        end else if (op == 4'hB) begin
            for (int i = 0; i < NR; i++) if (rv[i] && rid[i] == id && radr[i] == a) ok = 1;
            if (ok) begin
                ref_mem[a] = merge(old, d, be);
                kill_addr(a);
            end
            for (int i = 0; i < NR; i++) if (rid[i] == id) rv[i] = 0;
            exp_q.push_back({ok ? 32'd0 : 32'd1, meta});
        end else if (wr) begin
            ref_mem[a] = merge(old, d, be);
            kill_addr(a);
        end else begin
            exp_q.push_back({old, meta});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be, input logic [IW-1:0] id);
        int waited = 0;
        in_valid_i = 1'b1; in_amo_i = op; in_write_i = wr; in_addr_i = a;
        in_wdata_i = d; in_be_i = be; in_id_i = id; in_meta_i = meta_cnt;
        forever begin
            @(negedge clk_i);
            if (in_ready_o || waited >= 200) break;
            waited++;
        end
        check("accept_in_time", in_ready_o, 1'b1);
        if (in_ready_o) model_accept(op, wr, a, d, be, id, meta_cnt);
        meta_cnt++;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_mode = 0;
        ready_level = 1;
        while ((exp_q.size() != 0 || out_valid_o) && n < 300) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain_done", (exp_q.size() == 0) && !out_valid_o, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    resp_t mon_e;
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp rdata=%0h meta=%0h t=%0t", out_rdata_o, out_meta_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_rdata", out_rdata_o, mon_e.rdata);
                check("resp_meta", out_meta_o, mon_e.meta);
            end
        end
    end

    initial begin
        logic [3:0] rop;
        rst_ni = 1'b0; sram_clr = 1'b1; rand_mode = 0; ready_level = 1;
        in_valid_i = 0; in_amo_i = 0; in_write_i = 0; in_addr_i = 0;
        in_wdata_i = 0; in_be_i = 0; in_id_i = 0; in_meta_i = 0; out_ready_i = 1;
        meta_cnt = 16'h100; rvic = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int i = 0; i < NR; i++) begin rv[i] = 0; rid[i] = '0; radr[i] = '0; end
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_bank_req", bank_req_o, 1'b0);
        check("rst_out_rdata", out_rdata_o, 32'h0);
        check("rst_out_meta", out_meta_o, 16'h0);
        rst_ni = 1'b1; sram_clr = 1'b0;
        @(posedge clk_i);
        #1;
        check("idle_in_ready", in_ready_o, 1'b1);

        // plain write then read, one-cycle response latency
        issue(AmoNone, 1, 8'h10, 32'h5, 4'hF, 0);
        repeat (2) @(posedge clk_i);
        #1;
        check("write_no_resp", out_valid_o, 1'b0);
        issue(AmoNone, 0, 8'h10, 32'h0, 4'hF, 0);
        check("rd_not_valid_same_cycle", out_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("rd_valid_next_cycle", out_valid_o, 1'b1);
        drain();

        // AMO ADD stalls the request port during write-back
        issue(AmoAdd, 0, 8'h10, 32'h3, 4'hF, 0);
        check("amo_wb_in_ready", in_ready_o, 1'b0);
        drain();
        check("amo_add_mem", sram[8'h10], 32'h8);

        // LR/SC success and repeated SC failure
        issue(AmoNone, 1, 8'h20, 32'h7, 4'hF, 0);
        issue(AmoLR, 0, 8'h20, 32'h0, 4'hF, 1);
        issue(AmoSC, 0, 8'h20, 32'hAA, 4'hF, 1);
        issue(AmoSC, 0, 8'h20, 32'hBB, 4'hF, 1);
        drain();
        check("sc_mem", sram[8'h20], 32'hAA);

        // intervening write breaks the reservation
        issue(AmoLR, 0, 8'h20, 32'h0, 4'hF, 1);
        issue(AmoNone, 1, 8'h20, 32'h3, 4'hF, 2);
        issue(AmoSC, 0, 8'h20, 32'h9, 4'hF, 1);
        drain();
        check("sc_after_write_mem", sram[8'h20], 32'h3);

        // five LRs overflow four slots: id0 evicted
        for (int i = 0; i < 5; i++) issue(AmoLR, 0, AW'(8'h40 + i), 32'h0, 4'hF, IW'(i));
        issue(AmoSC, 0, 8'h40, 32'h11, 4'hF, 0);
        issue(AmoSC, 0, 8'h44, 32'h55, 4'hF, 4);
        drain();
        check("evicted_sc_mem", sram[8'h40], 32'h0);
        check("kept_sc_mem", sram[8'h44], 32'h55);

        // credit stall with out_ready low
        ready_level = 0;
        @(posedge clk_i);
        #1;
        issue(AmoNone, 0, 8'h10, 32'h0, 4'hF, 0);
        issue(AmoNone, 0, 8'h20, 32'h0, 4'hF, 0);
        in_valid_i = 1; in_amo_i = AmoNone; in_write_i = 0; in_addr_i = 8'h44;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("credit_stall", in_ready_o, 1'b0);
        end
        ready_level = 1;
        issue(AmoNone, 0, 8'h44, 32'h0, 4'hF, 0);
        drain();

        // signed vs unsigned minimum
        issue(AmoNone, 1, 8'h50, 32'hFFFF_FFFF, 4'hF, 0);
        issue(AmoMin, 0, 8'h50, 32'h1, 4'hF, 0);
        issue(AmoNone, 1, 8'h51, 32'hFFFF_FFFF, 4'hF, 0);
        issue(AmoMinu, 0, 8'h51, 32'h1, 4'hF, 0);
        drain();
        check("amo_min_mem", sram[8'h50], 32'hFFFF_FFFF);
        check("amo_minu_mem", sram[8'h51], 32'h1);

        // randomized traffic on a small contended address window
        rand_mode = 1;
        for (int n = 0; n < 400; n++) begin
            rop = 4'($urandom_range(0, 15));
            issue(rop, 1'($urandom_range(0, 1)), AW'(8'h80 + $urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 9)),
                  BW'($urandom_range(0, 15)), IW'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i);
                #1;
            end
        end
        drain();
        for (int i = 0; i < 8; i++) check("rand_mem", sram[8'h80 + i], ref_mem[8'h80 + i]);

        // reset during AMO write-back must suppress the write
        issue(AmoNone, 1, 8'h30, 32'h1234, 4'hF, 0);
        drain();
        issue(AmoAdd, 0, 8'h30, 32'h1, 4'hF, 0);
        rst_ni = 1'b0;
        #1;
        check("midamo_bank_req", bank_req_o, 1'b0);
        check("midamo_out_valid", out_valid_o, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("midamo_mem", sram[8'h30], 32'h1234);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_reset_ready", in_ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
